data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Load/store responder for a RISC-V style core: a 512 x 32 data RAM at
// 0x0000_0000-0x0000_07FF plus two memory-mapped LED registers
// (LEDR @ 0x0000_7000, LEDG @ 0x0000_7010). Everything else faults.
//
// Handshake: a request transfers on a rising edge where i_req_vld and
// o_req_rdy are both 1; a response transfers on a rising edge where
// o_rsp_vld and i_rsp_rdy are both 1. Once raised, o_rsp_vld and the
// response payload stay stable until that transfer. Requests offered
// while the block is busy (o_req_rdy=0) are simply not taken.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_req_vld/o_req_rdy   request handshake
//   i_req_we              1 = store, 0 = load
//   i_req_addr            byte address
//   i_req_wdata           store data, LSB-aligned
//   i_req_type            funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   o_rsp_vld/i_rsp_rdy   response handshake
//   o_rsp_rdata           extended load data (0 for stores and faults)
//   o_rsp_err             access fault flag
//   o_io_ledr, o_io_ledg  LED registers
//   o_dbg_state           FSM state (0 IDLE, 1 ACCESS, 2 RESP)
module data_mem_responder (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_type,
  output logic        o_rsp_vld,
  input  logic        i_rsp_rdy,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_type;

  logic [31:0] mem [0:511];
  logic [31:0] ram_q;
  logic [31:0] led_q;
  logic        src_led;
  logic        rsp_err;

  // Address / type decode on the latched request.
  logic       is_ram, is_ledr, is_ledg, type_bad, misaligned, fault;
  logic [8:0] idx;
  logic [3:0] be;
  logic [31:0] wlane;

  always_comb begin
    is_ram     = (req_addr[31:11] == 21'd0);
    is_ledr    = (req_addr == 32'h0000_7000);
    is_ledg    = (req_addr == 32'h0000_7010);
    type_bad   = (req_type == 3'b011) || (req_type == 3'b110) || (req_type == 3'b111);
    misaligned = ((req_type[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_type == 3'b010) && (req_addr[1:0] != 2'b00));
    fault      = type_bad || misaligned ||
                 !(is_ram || is_ledr || is_ledg) ||
                 ((is_ledr || is_ledg) && (req_type != 3'b010)) ||
                 (req_we && req_type[2]);
    idx        = req_addr[10:2];
    // Store data is replicated across lanes; byte enables pick the lane.
    be    = 4'b0000;
    wlane = req_wdata;
    case (req_type[1:0])
      2'b00: begin
        be    = 4'b0001 << req_addr[1:0];
        wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = req_wdata;
      end
    endcase
  end

  // FSM state register and request latch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      req_we    <= 1'b0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
      req_type  <= 3'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && i_req_vld) begin
        req_we    <= i_req_we;
        req_addr  <= i_req_addr;
        req_wdata <= i_req_wdata;
        req_type  <= i_req_type;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (i_rsp_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // LED registers and response side-band, committed at the ACCESS edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_io_ledr <= 32'd0;
      o_io_ledg <= 32'd0;
      led_q     <= 32'd0;
      src_led   <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      rsp_err <= fault;
      src_led <= is_ledr || is_ledg;
      led_q   <= is_ledr ? o_io_ledr : o_io_ledg;
      if (req_we && !fault && is_ledr) o_io_ledr <= req_wdata;
      if (req_we && !fault && is_ledg) o_io_ledg <= req_wdata;
    end
  end

  // Data RAM: synchronous read and byte-lane write, contents never reset.
  // Reset forces state to IDLE asynchronously, so an aborted ACCESS
  // cannot reach this write.
  always_ff @(posedge i_clk) begin
    if (state == ACCESS) begin
      ram_q <= mem[idx];
      if (req_we && !fault && is_ram) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  // Load extraction; gated by state so reset clears outputs at once.
  logic [31:0] word;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ext;

  always_comb begin
    word = src_led ? led_q : ram_q;
    bsel = 8'(word >> {req_addr[1:0], 3'b000});
    hsel = req_addr[1] ? word[31:16] : word[15:0];
    case (req_type)
      3'b000:  ext = {{24{bsel[7]}}, bsel};
      3'b001:  ext = {{16{hsel[15]}}, hsel};
      3'b010:  ext = word;
      3'b100:  ext = {24'd0, bsel};
      3'b101:  ext = {16'd0, hsel};
      default: ext = 32'd0;
    endcase
    o_req_rdy   = (state == IDLE);
    o_rsp_vld   = (state == RESP);
    o_rsp_err   = (state == RESP) && rsp_err;
    o_rsp_rdata = ((state == RESP) && !rsp_err && !req_we) ? ext : 32'd0;
    o_dbg_state = state;
  end

endmodule
